rx_frame_ctrl: RTL

Receive-side sequencer for the GMII PHY1 path.
- Strips preamble/SFD from phy1_rx_data and writes frame bytes into a two-bank packet RAM (2 x 2^ADDR_W bytes), so one bank fills while the consumer reads the other.
- Manages bank ownership and checks frame length.
- Hands completed frames to the consumer through a valid/ready descriptor interface; the consumer releases each bank explicitly.

---
 rtl/rx_ctrl_pkg.sv | 23 ++
 rtl/rx_desc_fifo.sv | 52 +++++
 rtl/rx_frame_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the PHY1 receive frame controller.
package rx_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_t;

  typedef enum logic [1:0] {FREE, FILLING, READY, OWNED} bank_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Length field is sized for the default 2048-byte bank.
  localparam int DESC_LEN_W = 11;

  typedef struct packed {
    logic                  bank;
    logic [DESC_LEN_W-1:0] len;
  } desc_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_desc_fifo.sv
// Two-entry first-word-fall-through descriptor FIFO.
module rx_desc_fifo
  import rx_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  push,
  input  desc_t push_data,
  input  logic  pop,
  output desc_t head,
  output logic  valid,
  output logic  full
);

  desc_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/rx_frame_ctrl.sv
// GMII PHY1 receive sequencer: strips preamble/SFD, stores frames into a
// two-bank packet RAM and hands finished frames to the consumer.
module rx_frame_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DESC_LEN_W,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic              phy1_rx_clk,
  input  logic              reset_n,
  input  logic              phy1_rx_dv,
  input  logic [7:0]        phy1_rx_data,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic              frm_bank,
  output logic [ADDR_W-1:0] frm_len,
  input  logic              rel_valid,
  input  logic              rel_bank,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       err_cnt
);

  localparam logic [ADDR_W-1:0] MIN_OFF = ADDR_W'(MIN_LEN);
  localparam logic [ADDR_W-1:0] MAX_OFF = ADDR_W'(MAX_LEN);

  rx_state_t         state;
  rx_state_t         state_nx;
  bank_state_t       bank_st [2];
  logic [ADDR_W-1:0] offset;
  logic              cur_bank;
  logic              any_free;
  logic              free_bank;
  logic              alloc;
  logic              wr_en;
  logic              push;
  logic              abort;
  logic              err_inc;
  logic              drop_inc;
  logic              accept;
  desc_t             push_desc;
  desc_t             head;
  logic              fifo_valid;
  logic              fifo_full;

  assign any_free  = (bank_st[0] == FREE) || (bank_st[1] == FREE);
  assign free_bank = (bank_st[0] == FREE) ? 1'b0 : 1'b1;

  // Descriptor handshake: frm_valid stays high with frm_bank/frm_len stable
  // until the consumer raises frm_ready; the transfer happens on the edge
  // where both are high, and the bank then belongs to the consumer until
  // it pulses rel_valid for it.
  assign accept = fifo_valid && frm_ready;

  always_ff @(posedge phy1_rx_clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    alloc    = 1'b0;
    wr_en    = 1'b0;
    push     = 1'b0;
    abort    = 1'b0;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state)
      IDLE: begin
        if (phy1_rx_dv) begin
          if (phy1_rx_data == PREAMBLE_BYTE) begin
            state_nx = PRE;
          end else begin
            state_nx = DROP;
            err_inc  = 1'b1;
          end
        end
      end
      PRE: begin
        if (!phy1_rx_dv) begin
          state_nx = IDLE;
        end else if (phy1_rx_data == PREAMBLE_BYTE) begin
          state_nx = PRE;
        end else if (phy1_rx_data == SFD_BYTE) begin
          if (any_free) begin
            alloc    = 1'b1;
            state_nx = DATA;
          end else begin
            drop_inc = 1'b1;
            state_nx = DROP;
          end
        end else begin
          err_inc  = 1'b1;
          state_nx = DROP;
        end
      end
      DATA: begin
        if (phy1_rx_dv) begin
          if (offset == MAX_OFF) begin
            abort    = 1'b1;
            err_inc  = 1'b1;
            state_nx = DROP;
          end else begin
            wr_en = 1'b1;
          end
        end else begin
          state_nx = IDLE;
          if (offset < MIN_OFF) begin
            abort   = 1'b1;
            err_inc = 1'b1;
          end else if (fifo_full) begin
            // Unreachable with two banks; kept so a full FIFO can never lose a bank.
            abort    = 1'b1;
            drop_inc = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      DROP: begin
        if (!phy1_rx_dv) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Each bank's transitions are keyed on a distinct current state, so at
  // most one event can touch a given bank per cycle.
  always_ff @(posedge phy1_rx_clk) begin
    if (!reset_n) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (bank_st[i])
          FREE:    if (alloc && free_bank == 1'(i)) bank_st[i] <= FILLING;
          FILLING: begin
            if (push && cur_bank == 1'(i)) begin
              bank_st[i] <= READY;
            end else if (abort && cur_bank == 1'(i)) begin
              bank_st[i] <= FREE;
            end
          end
          READY:   if (accept && head.bank == 1'(i)) bank_st[i] <= OWNED;
          OWNED:   if (rel_valid && rel_bank == 1'(i)) bank_st[i] <= FREE;
          default: bank_st[i] <= FREE;
        endcase
      end
    end
  end

  always_ff @(posedge phy1_rx_clk) begin
    if (!reset_n) begin
      offset    <= '0;
      cur_bank  <= 1'b0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      drop_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      if (alloc) begin
        cur_bank <= free_bank;
        offset   <= '0;
      end else if (wr_en) begin
        offset <= offset + 1'b1;
      end
      ram_we <= wr_en;
      if (wr_en) begin
        ram_waddr <= {cur_bank, offset};
        ram_wdata <= phy1_rx_data;
      end
      if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
      if (err_inc)  err_cnt  <= sat_inc(err_cnt);
    end
  end

  assign push_desc.bank = cur_bank;
  assign push_desc.len  = DESC_LEN_W'(offset);

  rx_desc_fifo u_desc_fifo (
    .clk       (phy1_rx_clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_desc),
    .pop       (frm_ready),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  assign frm_valid = fifo_valid;
  assign frm_bank  = head.bank;
  assign frm_len   = ADDR_W'(head.len);

endmodule
